cpu_lockstep_cmp: RTL and testbench
===================================

# cpu_lockstep_cmp

Lockstep bus-transaction comparator sitting downstream of the dual-CPU testbench top: it consumes the memory-bus transactions issued by the design-under-verification CPU and by the reference-model CPU, buffers each stream independently, and compares them in issue order. It reports mismatches, match and mismatch counts, a frozen capture of the first failing pair, buffer overflow, and (optionally) a stall watchdog. It is synthesizable so it can run in emulation as well as simulation.

## Interface
Parameters:
- DEPTH, 8: per-side FIFO entries; power of two, at least 2.
- CNT_W, 16: width of the match and mismatch counters.
- TIMEOUT, 256: watchdog limit in cycles (used only with CPU_CMP_TIMEOUT_EN).

Ports:
- clk  in  1  single clock; all logic on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- clr  in  1  synchronous clear of counters, sticky flags and FIFOs.
- duv_vld / ref_vld  in  1  the side's bus transaction is valid this cycle.
- duv_addr / ref_addr  in  16  bus address.
- duv_data / ref_data  in  8  write data, or read data returned.
- duv_we / ref_we  in  1  1 = write, 0 = read.
- mismatch  out  1  one-cycle pulse per miscompared pair.
- fail  out  1  sticky: first mismatch, overflow or timeout has occurred.
- overflow  out  1  sticky: a push was dropped on a full FIFO.
- timeout  out  1  sticky: watchdog expired (tied 0 when the feature is compiled out).
- match_cnt / mismatch_cnt  out  CNT_W  saturating counters.
- fst_duv / fst_ref  out  25  first failing pair, packed {we, addr, data}; frozen once fail is set.

## Operation
- Each side pushes {we, addr, data} into its own FIFO on every cycle where its vld is 1.
- Compare stage: when both FIFOs are non-empty, pop one entry from each and compare all 25 bits.
  - Equal: match_cnt increments.
  - Unequal: mismatch pulses and mismatch_cnt increments.
- FSM states:
  - RUN: normal operation.
  - FAIL: entered on the first mismatch, overflow or timeout. Comparison and counting continue. fst_* is captured only on the RUN to FAIL transition caused by a mismatch. If FAIL is entered by overflow or timeout, fst_* stays 0.
  - FAIL to RUN only on clr.
- Counters saturate at all-ones and do not wrap.
- Full FIFO: a push with no pop in the same cycle is dropped and overflow is set. Push and pop in the same cycle on a full FIFO is legal and loses nothing.
- Empty FIFO: no pop occurs; the other side waits.
- clr takes priority over any push, pop or compare in the same cycle.
- rst, including mid-operation, asynchronously clears everything.

## Timing
- Push at cycle N; the entry is poppable at N+1. If both sides push at N, the compare happens at N+1, and mismatch and the counters are updated at N+2 (registered).
- fail and fst_* are valid in the same cycle as the mismatch pulse.
- Sustained throughput: one compare per cycle.
- Reset values: mismatch=0, fail=0, overflow=0, timeout=0, match_cnt=0, mismatch_cnt=0, fst_duv=0, fst_ref=0, FIFOs empty, FSM in RUN.

## Configuration
- CPU_CMP_TIMEOUT_EN defined:
  - A counter runs while exactly one FIFO is non-empty, and resets on any pop or when both FIFOs are empty.
  - When the counter reaches TIMEOUT, timeout and fail are set.
- CPU_CMP_TIMEOUT_EN undefined: the watchdog logic is absent, timeout is tied to 0, and the TIMEOUT parameter is ignored.

## Structure
- cpu_cmp_pkg contains:
  - bus_txn_t packed struct {we, addr[15:0], data[7:0]};
  - cmp_state_e {RUN, FAIL};
  - the 25-bit TXN_W constant.
- Sub-module cpu_cmp_fifo: a synchronous bus_txn_t FIFO, instantiated once per side. It has push, pop, full, empty and a DEPTH parameter, and uses the same clk/rst.

## Test plan
- Identical streams: both sides push 10 equal transactions, e.g. read 16'hFFFC returning 8'h00 -> match_cnt=10, mismatch never pulses, fail=0.
- Data miscompare: the fourth transaction has duv_data=8'h42 and ref_data=8'h43 -> exactly one mismatch pulse, two cycles after the push. fail=1, fst_duv data=8'h42, fst_ref data=8'h43. Later mismatches leave fst_* unchanged.
- Skew: the ref side lags the duv side by 5 cycles on a 6-transaction stream (so the lag stays within DEPTH=8) -> all 6 pairs match and overflow=0.
- Overflow: duv pushes 9 transactions with ref idle and DEPTH=8 -> overflow=1 and fail=1. After clr, all flags and counters read 0.
- Timeout (with CPU_CMP_TIMEOUT_EN): one duv push, ref idle -> timeout=1 after TIMEOUT=256 cycles. Without the macro, timeout stays 0.
- Reset mid-stream: assert rst with 3 entries queued -> all outputs return to their reset values immediately; a subsequent equal pair gives match_cnt=1.

Source files
------------

// File: rtl/cpu_cmp_pkg.sv
// ---------------------------------------------------------------------------
// cpu_cmp_pkg
// Shared types for the lockstep bus-transaction comparator.
//   bus_txn_t   : one memory-bus transaction {we, addr, data}, 25 bits packed
//   cmp_state_e : comparator state, RUN until the first failure, then FAIL
//   TXN_W       : packed width of bus_txn_t
// ---------------------------------------------------------------------------
package cpu_cmp_pkg;

   localparam int TXN_W = 25;

   typedef struct packed {
      logic        we;
      logic [15:0] addr;
      logic [7:0]  data;
   } bus_txn_t;

   typedef enum logic [0:0] {
      RUN  = 1'b0,
      FAIL = 1'b1
   } cmp_state_e;

endpackage

// File: rtl/cpu_cmp_fifo.sv
// ---------------------------------------------------------------------------
// cpu_cmp_fifo
// Synchronous first-word-fall-through FIFO of bus_txn_t, one per CPU side.
// Ports:
//   clk, rst   : clock, asynchronous active-high reset
//   clr        : synchronous flush, overrides push and pop
//   push       : write push_data; accepted when not full, or when full and
//                a pop happens in the same cycle
//   push_data  : transaction to store
//   pop        : remove the head entry (ignored when empty)
//   pop_data   : current head entry (meaningful only when !empty)
//   full/empty : occupancy flags derived from registered pointers
// Parameter DEPTH must be a power of two, at least 2.
// ---------------------------------------------------------------------------
module cpu_cmp_fifo
   import cpu_cmp_pkg::*;
#(
   parameter int DEPTH = 8
) (
   input  logic     clk,
   input  logic     rst,
   input  logic     clr,
   input  logic     push,
   input  bus_txn_t push_data,
   input  logic     pop,
   output bus_txn_t pop_data,
   output logic     full,
   output logic     empty
);

   localparam int AW = $clog2(DEPTH);

   // One extra pointer bit distinguishes full from empty when indices match.
   logic [AW:0] wr_ptr_q, wr_ptr_d;
   logic [AW:0] rd_ptr_q, rd_ptr_d;
   bus_txn_t    mem_q [DEPTH];
   logic        wr_en_s;
   logic        rd_en_s;

   assign empty    = (wr_ptr_q == rd_ptr_q);
   assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign rd_en_s  = pop && !empty;
   // A full FIFO still accepts a push when the head leaves in the same cycle.
   assign wr_en_s  = push && (!full || rd_en_s);
   assign pop_data = mem_q[rd_ptr_q[AW-1:0]];

   // Next-state pointer arithmetic with flush priority.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (clr) begin
         wr_ptr_d = {(AW+1){1'b0}};
         rd_ptr_d = {(AW+1){1'b0}};
      end else begin
         if (wr_en_s) begin
            wr_ptr_d = wr_ptr_q + (AW+1)'(1);
         end else begin
            wr_ptr_d = wr_ptr_q;
         end
         if (rd_en_s) begin
            rd_ptr_d = rd_ptr_q + (AW+1)'(1);
         end else begin
            rd_ptr_d = rd_ptr_q;
         end
      end
   end

   // Pointer registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= {(AW+1){1'b0}};
         rd_ptr_q <= {(AW+1){1'b0}};
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   // Storage array; contents are only observed behind valid pointers, so no reset.
   always_ff @(posedge clk) begin
      if (wr_en_s && !clr) begin
         mem_q[wr_ptr_q[AW-1:0]] <= push_data;
      end
   end

endmodule

// File: rtl/cpu_lockstep_cmp.sv
// ---------------------------------------------------------------------------
// cpu_lockstep_cmp
// Lockstep comparator for the DUV and reference CPU memory-bus streams.
// Each stream is buffered in its own FIFO; whenever both hold an entry the
// heads are popped together and compared on all 25 bits.
// Ports:
//   clk, rst            : clock, asynchronous active-high reset
//   clr                 : synchronous clear of FIFOs, counters and flags
//   duv_* / ref_*       : per-side transaction (vld, addr, data, we)
//   mismatch            : one-cycle pulse per miscompared pair
//   fail                : sticky, first mismatch / overflow / timeout seen
//   overflow            : sticky, a push was dropped on a full FIFO
//   timeout             : sticky watchdog flag
//   match_cnt           : saturating count of equal pairs
//   mismatch_cnt        : saturating count of unequal pairs
//   fst_duv / fst_ref   : first failing pair {we, addr, data}; zero if the
//                         first failure was not a mismatch
// Optional feature macro: CPU_CMP_TIMEOUT_EN enables the stall watchdog
// (TIMEOUT cycles with exactly one FIFO non-empty). Without it, timeout is 0.
// ---------------------------------------------------------------------------
module cpu_lockstep_cmp
   import cpu_cmp_pkg::*;
#(
   parameter int DEPTH   = 8,
   parameter int CNT_W   = 16,
   parameter int TIMEOUT = 256
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             duv_vld,
   input  logic [15:0]      duv_addr,
   input  logic [7:0]       duv_data,
   input  logic             duv_we,
   input  logic             ref_vld,
   input  logic [15:0]      ref_addr,
   input  logic [7:0]       ref_data,
   input  logic             ref_we,
   output logic             mismatch,
   output logic             fail,
   output logic             overflow,
   output logic             timeout,
   output logic [CNT_W-1:0] match_cnt,
   output logic [CNT_W-1:0] mismatch_cnt,
   output logic [TXN_W-1:0] fst_duv,
   output logic [TXN_W-1:0] fst_ref
);

   // Elaboration-time parameter sanity checks.
   if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
      $error("cpu_lockstep_cmp: DEPTH must be a power of two >= 2");
   end
   if (TIMEOUT < 1) begin : g_bad_timeout
      $error("cpu_lockstep_cmp: TIMEOUT must be >= 1");
   end

   bus_txn_t   duv_in_s, ref_in_s;
   bus_txn_t   duv_head_s, ref_head_s;
   logic       duv_full_s, duv_empty_s;
   logic       ref_full_s, ref_empty_s;
   logic       cmp_en_s;
   logic       pair_eq_s;
   logic       drop_s;
   logic       wd_hit_s;

   cmp_state_e       state_q, state_d;
   logic             mismatch_q, mismatch_d;
   logic             overflow_q, overflow_d;
   logic [CNT_W-1:0] match_cnt_q, match_cnt_d;
   logic [CNT_W-1:0] mismatch_cnt_q, mismatch_cnt_d;
   logic [TXN_W-1:0] fst_duv_q, fst_duv_d;
   logic [TXN_W-1:0] fst_ref_q, fst_ref_d;

   assign duv_in_s = '{we: duv_we, addr: duv_addr, data: duv_data};
   assign ref_in_s = '{we: ref_we, addr: ref_addr, data: ref_data};

   // clr suppresses the compare so nothing is popped or counted that cycle.
   assign cmp_en_s  = !duv_empty_s && !ref_empty_s && !clr;
   assign pair_eq_s = (duv_head_s == ref_head_s);
   // A push is lost only when its FIFO is full and no compare frees a slot.
   assign drop_s    = !clr && !cmp_en_s &&
                      ((duv_vld && duv_full_s) || (ref_vld && ref_full_s));

   cpu_cmp_fifo #(.DEPTH(DEPTH)) u_duv_fifo (
      .clk       (clk),
      .rst       (rst),
      .clr       (clr),
      .push      (duv_vld),
      .push_data (duv_in_s),
      .pop       (cmp_en_s),
      .pop_data  (duv_head_s),
      .full      (duv_full_s),
      .empty     (duv_empty_s)
   );

   cpu_cmp_fifo #(.DEPTH(DEPTH)) u_ref_fifo (
      .clk       (clk),
      .rst       (rst),
      .clr       (clr),
      .push      (ref_vld),
      .push_data (ref_in_s),
      .pop       (cmp_en_s),
      .pop_data  (ref_head_s),
      .full      (ref_full_s),
      .empty     (ref_empty_s)
   );

`ifdef CPU_CMP_TIMEOUT_EN
   localparam int WD_W = $clog2(TIMEOUT + 1);

   logic [WD_W-1:0] wd_cnt_q, wd_cnt_d;
   logic            timeout_q, timeout_d;

   assign wd_hit_s = !clr && (wd_cnt_q == WD_W'(TIMEOUT));

   // Watchdog: counts while exactly one side has data. Pops only happen
   // when both sides are non-empty, so the "other" states cover every pop.
   always_comb begin
      wd_cnt_d  = wd_cnt_q;
      timeout_d = timeout_q;
      if (clr) begin
         wd_cnt_d  = {WD_W{1'b0}};
         timeout_d = 1'b0;
      end else begin
         if (duv_empty_s ^ ref_empty_s) begin
            if (wd_cnt_q != WD_W'(TIMEOUT)) begin
               wd_cnt_d = wd_cnt_q + WD_W'(1);
            end else begin
               wd_cnt_d = wd_cnt_q;
            end
         end else begin
            wd_cnt_d = {WD_W{1'b0}};
         end
         timeout_d = timeout_q || wd_hit_s;
      end
   end

   // Watchdog registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wd_cnt_q  <= {WD_W{1'b0}};
         timeout_q <= 1'b0;
      end else begin
         wd_cnt_q  <= wd_cnt_d;
         timeout_q <= timeout_d;
      end
   end

   assign timeout = timeout_q;
`else
   assign wd_hit_s = 1'b0;
   assign timeout  = 1'b0;
`endif

   // Compare result, saturating counters, sticky flags and first-fail capture.
   always_comb begin
      state_d        = state_q;
      mismatch_d     = 1'b0;
      overflow_d     = overflow_q;
      match_cnt_d    = match_cnt_q;
      mismatch_cnt_d = mismatch_cnt_q;
      fst_duv_d      = fst_duv_q;
      fst_ref_d      = fst_ref_q;
      if (clr) begin
         state_d        = RUN;
         overflow_d     = 1'b0;
         match_cnt_d    = {CNT_W{1'b0}};
         mismatch_cnt_d = {CNT_W{1'b0}};
         fst_duv_d      = {TXN_W{1'b0}};
         fst_ref_d      = {TXN_W{1'b0}};
      end else begin
         if (cmp_en_s && pair_eq_s) begin
            if (match_cnt_q != {CNT_W{1'b1}}) begin
               match_cnt_d = match_cnt_q + CNT_W'(1);
            end else begin
               match_cnt_d = match_cnt_q;
            end
         end else if (cmp_en_s) begin
            mismatch_d = 1'b1;
            if (mismatch_cnt_q != {CNT_W{1'b1}}) begin
               mismatch_cnt_d = mismatch_cnt_q + CNT_W'(1);
            end else begin
               mismatch_cnt_d = mismatch_cnt_q;
            end
         end else begin
            mismatch_d = 1'b0;
         end

         if (drop_s) begin
            overflow_d = 1'b1;
         end else begin
            overflow_d = overflow_q;
         end

         // Only a mismatch-driven entry into FAIL records the failing pair.
         case (state_q)
            RUN: begin
               if (cmp_en_s && !pair_eq_s) begin
                  state_d   = FAIL;
                  fst_duv_d = duv_head_s;
                  fst_ref_d = ref_head_s;
               end else if (drop_s || wd_hit_s) begin
                  state_d = FAIL;
               end else begin
                  state_d = RUN;
               end
            end
            FAIL:    state_d = FAIL;
            default: state_d = RUN;
         endcase
      end
   end

   // Comparator state and output registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q        <= RUN;
         mismatch_q     <= 1'b0;
         overflow_q     <= 1'b0;
         match_cnt_q    <= {CNT_W{1'b0}};
         mismatch_cnt_q <= {CNT_W{1'b0}};
         fst_duv_q      <= {TXN_W{1'b0}};
         fst_ref_q      <= {TXN_W{1'b0}};
      end else begin
         state_q        <= state_d;
         mismatch_q     <= mismatch_d;
         overflow_q     <= overflow_d;
         match_cnt_q    <= match_cnt_d;
         mismatch_cnt_q <= mismatch_cnt_d;
         fst_duv_q      <= fst_duv_d;
         fst_ref_q      <= fst_ref_d;
      end
   end

   assign mismatch     = mismatch_q;
   assign fail         = (state_q == FAIL);
   assign overflow     = overflow_q;
   assign match_cnt    = match_cnt_q;
   assign mismatch_cnt = mismatch_cnt_q;
   assign fst_duv      = fst_duv_q;
   assign fst_ref      = fst_ref_q;

endmodule

// File: tb/tb_cpu_lockstep_cmp.sv
// ---------------------------------------------------------------------------
// tb_cpu_lockstep_cmp
// Directed bench for cpu_lockstep_cmp (DEPTH=8, CNT_W=4 so that counter
// saturation is reachable, TIMEOUT=256). Inputs change and outputs are
// sampled 1 time unit after the rising edge.
// ---------------------------------------------------------------------------
module tb_cpu_lockstep_cmp;

   logic        clk = 1'b0;
   logic        rst;
   logic        clr;
   logic        duv_vld, ref_vld;
   logic [15:0] duv_addr, ref_addr;
   logic [7:0]  duv_data, ref_data;
   logic        duv_we, ref_we;
   logic        mismatch, fail, overflow, timeout;
   logic [3:0]  match_cnt, mismatch_cnt;
   logic [24:0] fst_duv, fst_ref;

   int total = 0;
   int bad   = 0;
   int pulses = 0;
   int base;

   cpu_lockstep_cmp #(.DEPTH(8), .CNT_W(4), .TIMEOUT(256)) dut (
      .clk          (clk),
      .rst          (rst),
      .clr          (clr),
      .duv_vld      (duv_vld),
      .duv_addr     (duv_addr),
      .duv_data     (duv_data),
      .duv_we       (duv_we),
      .ref_vld      (ref_vld),
      .ref_addr     (ref_addr),
      .ref_data     (ref_data),
      .ref_we       (ref_we),
      .mismatch     (mismatch),
      .fail         (fail),
      .overflow     (overflow),
      .timeout      (timeout),
      .match_cnt    (match_cnt),
      .mismatch_cnt (mismatch_cnt),
      .fst_duv      (fst_duv),
      .fst_ref      (fst_ref)
   );

   always #5 clk = ~clk;

   // Counts mismatch pulses, sampled mid-cycle.
   always @(negedge clk) begin
      if (mismatch === 1'b1) pulses = pulses + 1;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      total++;
      assert (obs === exp_v) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   // One cycle of pushes; dt/rt are {we, addr, data}.
   task automatic push(input logic dv, input logic rv, input logic [24:0] dt, input logic [24:0] rt);
      duv_vld = dv;
      ref_vld = rv;
      {duv_we, duv_addr, duv_data} = dt;
      {ref_we, ref_addr, ref_data} = rt;
      cyc();
      duv_vld = 1'b0;
      ref_vld = 1'b0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc();
   endtask

   task automatic do_clr();
      clr = 1'b1;
      cyc();
      clr = 1'b0;
   endtask

   initial begin
      logic [24:0] t;
      logic [24:0] r;
      rst = 1'b1; clr = 1'b0;
      duv_vld = 1'b0; ref_vld = 1'b0;
      duv_addr = 16'h0000; ref_addr = 16'h0000;
      duv_data = 8'h00; ref_data = 8'h00;
      duv_we = 1'b0; ref_we = 1'b0;
      idle(2);

      // Reset state
      chk("rst_mismatch", {31'd0, mismatch}, 32'd0);
      chk("rst_fail", {31'd0, fail}, 32'd0);
      chk("rst_overflow", {31'd0, overflow}, 32'd0);
      chk("rst_timeout", {31'd0, timeout}, 32'd0);
      chk("rst_match_cnt", {28'd0, match_cnt}, 32'd0);
      chk("rst_mm_cnt", {28'd0, mismatch_cnt}, 32'd0);
      chk("rst_fst_duv", {7'd0, fst_duv}, 32'd0);
      chk("rst_fst_ref", {7'd0, fst_ref}, 32'd0);
      rst = 1'b0;
      idle(1);

      // Identical streams: 10 reads of 16'hFFFC returning 8'h00
      base = pulses;
      for (int i = 0; i < 10; i++) push(1'b1, 1'b1, {1'b0, 16'hFFFC, 8'h00}, {1'b0, 16'hFFFC, 8'h00});
      idle(3);
      chk("ident_match_cnt", {28'd0, match_cnt}, 32'd10);
      chk("ident_mm_cnt", {28'd0, mismatch_cnt}, 32'd0);
      chk("ident_pulses", pulses - base, 32'd0);
      chk("ident_fail", {31'd0, fail}, 32'd0);

      // Saturation: 10 more matches on a 4-bit counter stop at 15
      for (int i = 0; i < 10; i++) push(1'b1, 1'b1, {1'b1, 16'h0100, 8'h5A}, {1'b1, 16'h0100, 8'h5A});
      idle(3);
      chk("sat_match_cnt", {28'd0, match_cnt}, 32'd15);

      // Data miscompare on 4th transaction
      do_clr();
      chk("clr_match_cnt", {28'd0, match_cnt}, 32'd0);
      base = pulses;
      push(1'b1, 1'b1, {1'b1, 16'h1000, 8'h40}, {1'b1, 16'h1000, 8'h40});
      push(1'b1, 1'b1, {1'b1, 16'h1001, 8'h41}, {1'b1, 16'h1001, 8'h41});
      push(1'b1, 1'b1, {1'b1, 16'h1002, 8'h42}, {1'b1, 16'h1002, 8'h42});
      push(1'b1, 1'b1, {1'b1, 16'h1003, 8'h42}, {1'b1, 16'h1003, 8'h43});
      chk("mc_no_early_pulse", {31'd0, mismatch}, 32'd0);
      chk("mc_no_early_fail", {31'd0, fail}, 32'd0);
      push(1'b1, 1'b1, {1'b1, 16'h1004, 8'h44}, {1'b1, 16'h1004, 8'h44});
      chk("mc_pulse", {31'd0, mismatch}, 32'd1);
      chk("mc_fail", {31'd0, fail}, 32'd1);
      chk("mc_fst_duv", {7'd0, fst_duv}, {7'd0, 1'b1, 16'h1003, 8'h42});
      chk("mc_fst_ref", {7'd0, fst_ref}, {7'd0, 1'b1, 16'h1003, 8'h43});
      push(1'b1, 1'b1, {1'b0, 16'h1005, 8'h55}, {1'b0, 16'h1005, 8'h66});
      chk("mc_pulse_one_cycle", {31'd0, mismatch}, 32'd0);
      idle(1);
      chk("mc_second_pulse", {31'd0, mismatch}, 32'd1);
      chk("mc_fst_duv_frozen", {7'd0, fst_duv}, {7'd0, 1'b1, 16'h1003, 8'h42});
      chk("mc_fst_ref_frozen", {7'd0, fst_ref}, {7'd0, 1'b1, 16'h1003, 8'h43});
      idle(2);
      chk("mc_mm_cnt", {28'd0, mismatch_cnt}, 32'd2);
      chk("mc_match_cnt", {28'd0, match_cnt}, 32'd4);
      chk("mc_pulses", pulses - base, 32'd2);

      // Skew: ref lags duv by 5 cycles on 6 transactions
      do_clr();
      chk("clr_fail", {31'd0, fail}, 32'd0);
      for (int c = 0; c < 11; c++) begin
         t = {c[0], 16'h2000 + 16'(c), 8'h10 + 8'(c)};
         r = {1'b0, 16'h2000 + 16'(c - 5), 8'h10 + 8'(c - 5)};
         r[24] = 1'(c - 5);
         push(c < 6, c >= 5, t, r);
      end
      idle(3);
      chk("skew_match_cnt", {28'd0, match_cnt}, 32'd6);
      chk("skew_mm_cnt", {28'd0, mismatch_cnt}, 32'd0);
      chk("skew_overflow", {31'd0, overflow}, 32'd0);
      chk("skew_fail", {31'd0, fail}, 32'd0);

      // Full FIFO with push and pop in the same cycle loses nothing
      do_clr();
      for (int i = 0; i < 8; i++) push(1'b1, 1'b0, {1'b0, 16'h4000 + 16'(i), 8'(i)}, 25'd0);
      push(1'b0, 1'b1, 25'd0, {1'b0, 16'h4000, 8'h00});
      push(1'b1, 1'b1, {1'b0, 16'h4008, 8'h08}, {1'b0, 16'h4001, 8'h01});
      for (int i = 2; i < 9; i++) push(1'b0, 1'b1, 25'd0, {1'b0, 16'h4000 + 16'(i), 8'(i)});
      idle(3);
      chk("fullpp_match_cnt", {28'd0, match_cnt}, 32'd9);
      chk("fullpp_overflow", {31'd0, overflow}, 32'd0);
      chk("fullpp_mm_cnt", {28'd0, mismatch_cnt}, 32'd0);

      // Overflow: 9 duv pushes, ref idle
      do_clr();
      for (int i = 0; i < 8; i++) push(1'b1, 1'b0, {1'b1, 16'h5000 + 16'(i), 8'hA0}, 25'd0);
      chk("ovf_not_yet", {31'd0, overflow}, 32'd0);
      push(1'b1, 1'b0, {1'b1, 16'h5008, 8'hA0}, 25'd0);
      chk("ovf_set", {31'd0, overflow}, 32'd1);
      chk("ovf_fail", {31'd0, fail}, 32'd1);
      chk("ovf_fst_duv_zero", {7'd0, fst_duv}, 32'd0);
      chk("ovf_fst_ref_zero", {7'd0, fst_ref}, 32'd0);
      do_clr();
      chk("ovf_clr_overflow", {31'd0, overflow}, 32'd0);
      chk("ovf_clr_fail", {31'd0, fail}, 32'd0);
      chk("ovf_clr_match", {28'd0, match_cnt}, 32'd0);
      chk("ovf_clr_mm", {28'd0, mismatch_cnt}, 32'd0);
      push(1'b1, 1'b1, {1'b0, 16'h6000, 8'h11}, {1'b0, 16'h6000, 8'h11});
      idle(1);
      chk("ovf_clr_fifo_empty", {28'd0, match_cnt}, 32'd1);
      chk("ovf_clr_no_mm", {28'd0, mismatch_cnt}, 32'd0);

      // Watchdog: one duv push, ref idle
      do_clr();
      push(1'b1, 1'b0, {1'b0, 16'h7000, 8'h00}, 25'd0);
      idle(200);
      chk("wd_early", {31'd0, timeout}, 32'd0);
      idle(100);
`ifdef CPU_CMP_TIMEOUT_EN
      chk("wd_timeout", {31'd0, timeout}, 32'd1);
      chk("wd_fail", {31'd0, fail}, 32'd1);
      chk("wd_fst_duv_zero", {7'd0, fst_duv}, 32'd0);
`else
      chk("wd_timeout_off", {31'd0, timeout}, 32'd0);
      chk("wd_fail_off", {31'd0, fail}, 32'd0);
`endif

      // Reset mid-stream with 3 entries queued
      do_clr();
      push(1'b1, 1'b1, {1'b0, 16'h3000, 8'h01}, {1'b0, 16'h3000, 8'h02});
      idle(1);
      chk("mrst_pre_fail", {31'd0, fail}, 32'd1);
      for (int i = 0; i < 3; i++) push(1'b1, 1'b0, {1'b1, 16'h3100 + 16'(i), 8'h77}, 25'd0);
      #3;
      rst = 1'b1;
      #1;
      chk("mrst_fail", {31'd0, fail}, 32'd0);
      chk("mrst_mm_cnt", {28'd0, mismatch_cnt}, 32'd0);
      chk("mrst_fst_duv", {7'd0, fst_duv}, 32'd0);
      chk("mrst_fst_ref", {7'd0, fst_ref}, 32'd0);
      chk("mrst_overflow", {31'd0, overflow}, 32'd0);
      cyc();
      rst = 1'b0;
      push(1'b1, 1'b1, {1'b1, 16'h3200, 8'h99}, {1'b1, 16'h3200, 8'h99});
      idle(1);
      chk("mrst_match_cnt", {28'd0, match_cnt}, 32'd1);
      chk("mrst_post_mm_cnt", {28'd0, mismatch_cnt}, 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
